// File: rtl/des_pkg.sv
// DES key-schedule constants and the small combinational helpers
// (PC-1 selection, 28-bit rotators, per-round shift amount).
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 28;
  localparam int SUBKEY_W = 48;

  // DES bit numbering: bit 1 is the MSB of the vector.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [2*CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [2*CD_W-1:0] cd;
    cd = '0;
    for (int i = 0; i < 2*CD_W; i++)
      cd[2*CD_W-1-i] = key[KEY_W-PC1[i]];
    return cd;
  endfunction

  function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic [1:0] n);
    return (x << n) | (x >> (5'd28 - {3'd0, n}));
  endfunction

  function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic [1:0] n);
    return (x >> n) | (x << (5'd28 - {3'd0, n}));
  endfunction

  function automatic logic [1:0] shift_amt(input logic [3:0] r);
    return SHIFT_SCHED[r];
  endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression permutation: 56-bit {C,D} to 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [2*CD_W-1:0]   cd_i,
  output logic [SUBKEY_W-1:0] subkey_o
);

  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
    assign subkey_o[SUBKEY_W-1-i] = cd_i[2*CD_W-PC2[i]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES round-subkey generator: one subkey per accepted round advance, encrypt
// order with left rotations, decrypt order with right rotations.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_load,
  input  logic [KEY_W-1:0]    key_in,
  input  logic                decrypt,
  input  logic                round_adv,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                subkey_valid,
  output logic [3:0]          round_idx,
  output logic                last_round,
  output logic                busy
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  logic [CD_W-1:0] c_q, c_d, d_q, d_d;
  logic [CD_W-1:0] pc1_c, pc1_d;
  logic [3:0]      idx_q, idx_d;
  logic            mode_q, mode_d;
  logic            valid_q, valid_d;
  logic [1:0]      sh;

  assign {pc1_c, pc1_d} = pc1(key_in);

  // Decrypt walks the encrypt rotations backwards, so it reads the table from the end.
  assign sh = mode_q ? shift_amt(LAST_IDX - idx_q) : shift_amt(idx_q + 4'd1);

  always_comb begin
    c_d     = c_q;
    d_d     = d_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    if (key_load) begin
      mode_d  = decrypt;
      idx_d   = 4'd0;
      valid_d = 1'b1;
      c_d     = decrypt ? pc1_c : rotl28(pc1_c, shift_amt(4'd0));
      d_d     = decrypt ? pc1_d : rotl28(pd1_fix(pc1_d), shift_amt(4'd0));
    end else if (round_adv && valid_q) begin
      if (idx_q == LAST_IDX) begin
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + 4'd1;
        c_d   = mode_q ? rotr28(c_q, sh) : rotl28(c_q, sh);
        d_d   = mode_q ? rotr28(d_q, sh) : rotl28(d_q, sh);
      end
    end
  end

  function automatic logic [CD_W-1:0] pd1_fix(input logic [CD_W-1:0] x);
    return x;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      c_q     <= c_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_i     ({c_q, d_q}),
    .subkey_o (subkey)
  );

  assign subkey_valid = valid_q;
  assign round_idx    = idx_q;
  assign last_round   = valid_q & (idx_q == LAST_IDX);
  assign busy         = valid_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomized bench for des_key_schedule against a bit-array DES key-schedule model
// built from cumulative rotation counts.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_load = 1'b0;
  logic [63:0] key_in = '0;
  logic        decrypt = 1'b0;
  logic        round_adv = 1'b0;
  logic [47:0] subkey;
  logic        subkey_valid, last_round, busy;
  logic [3:0]  round_idx;

  des_key_schedule #(.NUM_ROUNDS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_load     (key_load),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .round_adv    (round_adv),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round_idx    (round_idx),
    .last_round   (last_round),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  localparam int T_PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
    7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int T_PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
    23,19,12,4,26,8, 16,7,27,20,13,2, 41,52,31,37,47,55,
    30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int T_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] KAT_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] KAT_K16 = 48'hCB3D8B0E17F5;

  int n_vec = 0;
  int n_err = 0;

  logic [47:0] m_keys [16];
  int          m_idx;
  bit          m_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Round r key uses C0/D0 rotated left by the cumulative shift count through r.
  task automatic build_sched(input logic [63:0] k, input bit dec);
    bit kb [1:64];
    bit cd0 [1:56];
    bit cdr [1:56];
    int s;
    logic [47:0] ks;
    for (int i = 1; i <= 64; i++) kb[i] = k[64-i];
    for (int j = 1; j <= 56; j++) cd0[j] = kb[T_PC1[j-1]];
    s = 0;
    for (int r = 0; r < 16; r++) begin
      s += T_SH[r];
      for (int i = 1; i <= 28; i++) begin
        cdr[i]    = cd0[((i - 1 + s) % 28) + 1];
        cdr[28+i] = cd0[28 + ((i - 1 + s) % 28) + 1];
      end
      ks = '0;
      for (int b = 1; b <= 48; b++) ks[48-b] = cdr[T_PC2[b-1]];
      m_keys[dec ? 15 - r : r] = ks;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_keys[i] = '0;
    m_idx   = 0;
    m_valid = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [6:0] exp_st, obs_st;
    exp_st = {m_valid, 4'(m_idx), m_valid && (m_idx == 15), m_valid};
    obs_st = {subkey_valid, round_idx, last_round, busy};
    chk({tag, ".subkey"}, {16'h0, subkey}, {16'h0, m_keys[m_idx]});
    chk({tag, ".status"}, {57'h0, obs_st}, {57'h0, exp_st});
  endtask

  task automatic step(input string tag, input bit ld, input logic [63:0] k,
                      input bit dec, input bit adv);
    @(negedge clk);
    key_load = ld; key_in = k; decrypt = dec; round_adv = adv;
    @(posedge clk);
    if (ld) begin
      build_sched(k, dec);
      m_idx = 0;
      m_valid = 1;
    end else if (adv && m_valid) begin
      if (m_idx == 15) m_valid = 0;
      else m_idx++;
    end
    #1 check_outputs(tag);
  endtask

  // Advance with random gaps until the model reaches the target index.
  task automatic run_to(input string tag, input int target);
    int guard;
    guard = 0;
    while (m_idx < target && m_valid && guard < 400) begin
      step(tag, 0, {$urandom, $urandom}, $urandom_range(0, 1), $urandom_range(0, 1));
      guard++;
    end
    if (m_idx != target) chk({tag, ".reach"}, 64'(m_idx), 64'(target));
  endtask

  logic [47:0] held;

  initial begin
    model_reset();
    #1 check_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    step("idle_adv", 0, '0, 0, 1);
    step("idle_adv2", 0, '0, 1, 1);

    // Known-answer encrypt schedule.
    step("enc_load", 1, KAT_KEY, 0, 0);
    chk("enc_K1", {16'h0, subkey}, {16'h0, KAT_K1});
    run_to("enc", 15);
    chk("enc_K16", {16'h0, subkey}, {16'h0, KAT_K16});
    step("enc_end", 0, '0, 0, 1);
    chk("enc_end_valid", {61'h0, subkey_valid, last_round, busy}, 64'h0);
    step("enc_post1", 0, '0, 0, 1);
    step("enc_post2", 0, '0, 1, 1);

    // Known-answer decrypt schedule.
    step("dec_load", 1, KAT_KEY, 1, 0);
    chk("dec_K16", {16'h0, subkey}, {16'h0, KAT_K16});
    run_to("dec", 15);
    chk("dec_K1", {16'h0, subkey}, {16'h0, KAT_K1});
    step("dec_end", 0, '0, 1, 1);

    // Stall at idx3.
    step("stall_load", 1, {$urandom, $urandom}, 0, 0);
    run_to("stall", 3);
    held = subkey;
    for (int i = 0; i < 10; i++) step("stall_hold", 0, {$urandom, $urandom}, 1, 0);
    chk("stall_key", {16'h0, subkey}, {16'h0, held});
    run_to("stall_rest", 15);

    // key_load and round_adv collide at idx7.
    step("coll_load", 1, {$urandom, $urandom}, 1, 0);
    run_to("coll", 7);
    step("coll_hit", 1, {$urandom, $urandom}, 0, 1);
    chk("coll_idx", 64'(round_idx), 64'h0);

    // Asynchronous reset between edges at idx5.
    run_to("rst_pre", 5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_key", {16'h0, subkey}, 64'h0);
    chk("async_rst_st", {57'h0, subkey_valid, round_idx, last_round, busy}, 64'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step("post_rst_adv", 0, '0, 0, 1);
    step("post_rst_adv2", 0, '0, 1, 1);

    // Free-running random traffic.
    for (int i = 0; i < 600; i++)
      step("rand", ($urandom_range(0, 19) == 0), {$urandom, $urandom},
           $urandom_range(0, 1), $urandom_range(0, 2) != 0);

    @(negedge clk);
    key_load = 0; round_adv = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
